// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: conditions two push-buttons, runs the IDLE/COUNT/LAP/STOP FSM and
// paces the display counter with a prescaler. Outputs are registered from next-state values.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_lr,
  output logic       ci,
  output logic       ld,
  output logic       clr,
  output logic [1:0] state
);

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StCount = 2'b01,
    StLap   = 2'b10,
    StStop  = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [PreW-1:0] pre_q, pre_d;
  // Bit 0 is start/stop, bit 1 is lap/reset.
  logic [1:0]      s1_q, s2_q, prev_q;
  logic            ss_edge, lr_edge;
  logic            ci_q, ld_q, clr_q;
  logic            ci_d, ld_d, clr_d;

  assign ss_edge = s2_q[0] & ~prev_q[0];
  assign lr_edge = s2_q[1] & ~prev_q[1];

  // Start/stop takes priority over lap/reset when both arrive together.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (ss_edge) state_d = StCount;
      end
      StCount: begin
        if (ss_edge)      state_d = StStop;
        else if (lr_edge) state_d = StLap;
      end
      StLap: begin
        if (ss_edge)      state_d = StStop;
        else if (lr_edge) state_d = StCount;
      end
      StStop: begin
        if (ss_edge)      state_d = StCount;
        else if (lr_edge) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // STOP holds the prescaler so the tick phase survives a stop/resume.
  always_comb begin
    pre_d = pre_q;
    if (state_q == StIdle || state_d == StIdle) begin
      pre_d = '0;
    end else if (state_q == StCount || state_q == StLap) begin
      pre_d = (pre_q == PreMax) ? '0 : pre_q + 1'b1;
    end
  end

  always_comb begin
    ci_d  = (state_d == StCount || state_d == StLap) && (pre_d == PreMax);
    ld_d  = (state_d == StCount || state_d == StStop);
    clr_d = (state_d == StIdle);
  end

  // Synchronizers reset high so a button held through reset yields no edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 2'b11;
      s2_q    <= 2'b11;
      prev_q  <= 2'b11;
      state_q <= StIdle;
      pre_q   <= '0;
      ci_q    <= 1'b0;
      ld_q    <= 1'b0;
      clr_q   <= 1'b1;
    end else begin
      s1_q    <= {btn_lr, btn_ss};
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      state_q <= state_d;
      pre_q   <= pre_d;
      ci_q    <= ci_d;
      ld_q    <= ld_d;
      clr_q   <= clr_d;
    end
  end

  assign ci    = ci_q;
  assign ld    = ld_q;
  assign clr   = clr_q;
  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: TICK_DIV=4 and TICK_DIV=1 instances share stimulus; a
// sample-history model is compared every cycle, plus literal expectations per scenario.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_ss = 1'b0;
  logic       btn_lr = 1'b0;
  logic       ci4, ld4, clr4, ci1, ld1, clr1;
  logic [1:0] st4, st1;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_lr(btn_lr),
    .ci(ci4), .ld(ld4), .clr(clr4), .state(st4)
  );

  stopwatch_ctrl #(.TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_lr(btn_lr),
    .ci(ci1), .ld(ld1), .clr(clr1), .state(st1)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s t=%0t got %0h exp %0h", name, $time, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: a press takes effect at edge n when the button was sampled high at n-2 and low
  // at n-3; act counts COUNT/LAP cycles since leaving IDLE and sets the tick phase.
  logic [1:0] mst = 2'd0;
  int         act = 0;
  logic [2:0] h_ss = 3'b111;
  logic [2:0] h_lr = 3'b111;
  bit         mvalid = 1'b0;
  logic       p_ss, p_lr;
  logic [1:0] nst;

  always @(posedge clk) begin
    if (rst) begin
      mst  = 2'd0;
      act  = 0;
      h_ss = 3'b111;
      h_lr = 3'b111;
    end else begin
      p_ss = h_ss[1] & ~h_ss[2];
      p_lr = h_lr[1] & ~h_lr[2];
      if (mst == 2'd1 || mst == 2'd2) act++;
      nst = mst;
      if (p_ss) nst = (mst == 2'd0 || mst == 2'd3) ? 2'd1 : 2'd3;
      else if (p_lr) begin
        if (mst == 2'd1) nst = 2'd2;
        else if (mst == 2'd2) nst = 2'd1;
        else if (mst == 2'd3) nst = 2'd0;
      end
      if (nst == 2'd0) act = 0;
      mst  = nst;
      h_ss = {h_ss[1:0], btn_ss};
      h_lr = {h_lr[1:0], btn_lr};
    end
    mvalid = 1'b1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("m_state4", st4, mst);
      chk("m_ci4", ci4, ((mst == 2'd1 || mst == 2'd2) && (act % 4 == 3)) ? 8'd1 : 8'd0);
      chk("m_ld4", ld4, (mst == 2'd1 || mst == 2'd3) ? 8'd1 : 8'd0);
      chk("m_clr4", clr4, (mst == 2'd0) ? 8'd1 : 8'd0);
      chk("m_state1", st1, mst);
      chk("m_ci1", ci1, (mst == 2'd1 || mst == 2'd2) ? 8'd1 : 8'd0);
      chk("m_ld1", ld1, (mst == 2'd1 || mst == 2'd3) ? 8'd1 : 8'd0);
      chk("m_clr1", clr1, (mst == 2'd0) ? 8'd1 : 8'd0);
    end
  end

  task automatic press_ss();
    btn_ss = 1'b1;
    step(1);
    btn_ss = 1'b0;
    step(2);
  endtask

  task automatic press_lr();
    btn_lr = 1'b1;
    step(1);
    btn_lr = 1'b0;
    step(2);
  endtask

  int npulse;
  int guard;

  initial begin
    step(2);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("idle_state", st4, 8'd0);
      chk("idle_ci", ci4, 8'd0);
      chk("idle_ld", ld4, 8'd0);
      chk("idle_clr", clr4, 8'd1);
      step(1);
    end
    btn_lr = 1'b1;
    step(3);
    btn_lr = 1'b0;
    step(4);
    chk("lr_in_idle", st4, 8'd0);

    // Start with a 3-cycle press.
    btn_ss = 1'b1;
    step(1);
    chk("start_lat1", st4, 8'd0);
    step(1);
    chk("start_lat2", st4, 8'd0);
    step(1);
    chk("start_state", st4, 8'd1);
    chk("start_ld", ld4, 8'd1);
    chk("start_clr", clr4, 8'd0);
    btn_ss = 1'b0;
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      npulse += int'(ci4);
      step(1);
    end
    chk("ci_pulses20", 8'(npulse), 8'd5);
    chk("held_once", st4, 8'd1);

    // Lap round trip.
    press_lr();
    chk("lap_state", st4, 8'd2);
    chk("lap_ld", ld4, 8'd0);
    npulse = 0;
    for (int i = 0; i < 8; i++) begin
      npulse += int'(ci4);
      step(1);
    end
    chk("lap_pulses8", 8'(npulse), 8'd2);
    press_lr();
    chk("unlap_state", st4, 8'd1);
    chk("unlap_ld", ld4, 8'd1);

    // Align to a tick, then stop two cycles later so the phase is held mid-period.
    guard = 0;
    while (ci4 !== 1'b1 && guard < 10) begin
      step(1);
      guard++;
    end
    chk("ci_seen", (guard < 10) ? 8'd1 : 8'd0, 8'd1);
    press_ss();
    for (int i = 0; i < 5; i++) begin
      chk("stop_state", st4, 8'd3);
      chk("stop_ci", ci4, 8'd0);
      step(1);
    end
    btn_ss = 1'b1;
    step(1);
    btn_ss = 1'b0;
    step(1);
    chk("resume_lat", st4, 8'd3);
    step(1);
    chk("resume_state", st4, 8'd1);
    chk("resume_ci0", ci4, 8'd0);
    step(1);
    chk("resume_ci1", ci4, 8'd1);

    // Simultaneous presses: start/stop wins, no LAP visit.
    btn_ss = 1'b1;
    btn_lr = 1'b1;
    step(1);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    chk("both_lat1", st4, 8'd1);
    step(1);
    chk("both_lat2", st4, 8'd1);
    step(1);
    chk("both_state", st4, 8'd3);

    press_lr();
    chk("clear_state", st4, 8'd0);
    chk("clear_clr", clr4, 8'd1);
    step(3);

    // Reset from LAP with start/stop held across it.
    press_ss();
    chk("run2_state", st4, 8'd1);
    step(5);
    press_lr();
    chk("run2_lap", st4, 8'd2);
    rst = 1'b1;
    btn_ss = 1'b1;
    step(1);
    chk("rst_state", st4, 8'd0);
    chk("rst_clr", clr4, 8'd1);
    chk("rst_ld", ld4, 8'd0);
    chk("rst_ci", ci4, 8'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("held_rst", st4, 8'd0);
      step(1);
    end
    btn_ss = 1'b0;
    step(3);
    chk("held_rst_end", st4, 8'd0);

    // TICK_DIV=1 gives a level count enable.
    press_ss();
    chk("div1_state", st1, 8'd1);
    for (int i = 0; i < 5; i++) begin
      chk("div1_ci", ci1, 8'd1);
      step(1);
    end
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
